insight_gpr_snapshot_tx: RTL

INSIGHT_GPR_SNAPSHOT_TX -- requirements
Module: insight_gpr_snapshot_tx

---
 rtl/insight_snap_pkg.sv | 38 +++
 rtl/insight_snap_shadow.sv | 35 +++
 rtl/insight_gpr_snapshot_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/insight_snap_pkg.sv
// Shared types and constants for the GPR snapshot streamer.
// Holds the FSM state enum, header layout and default sizes.
package insight_snap_pkg;

  localparam int DEF_NREGS = 31;
  localparam int DEF_XLEN  = 32;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_NREGS_LSB = 8;
  localparam int HDR_INT_BIT   = 1;
  localparam int HDR_EXC_BIT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY
  } snap_state_e;

  function automatic logic [31:0] make_hdr(
    input logic [7:0] seq,
    input logic [7:0] nregs,
    input logic       intr,
    input logic       exc
  );
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_SEQ_LSB +: 8]   = seq;
    h[HDR_NREGS_LSB +: 8] = nregs;
    h[HDR_INT_BIT]        = intr;
    h[HDR_EXC_BIT]        = exc;
    return h;
  endfunction

endpackage

// File: rtl/insight_snap_shadow.sv
// Shadow copy of the tapped GPRs with an indexed read port.
// Ports: clock, cap_en, gpr_in (x1 in LSBs), rd_idx -> rd_data.
module insight_snap_shadow
  import insight_snap_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int XLEN  = DEF_XLEN,
  parameter int IW    = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  cap_en,
  input  logic [NREGS*XLEN-1:0] gpr_in,
  input  logic [IW-1:0]         rd_idx,
  output logic [XLEN-1:0]       rd_data
);

  logic [XLEN-1:0] mem [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    always_ff @(posedge clock) begin
      if (cap_en) begin
        mem[i] <= gpr_in[i*XLEN +: XLEN];
      end
    end
  end

  // Index one past the last word is never consumed; return zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NREGS) begin
      rd_data = mem[rd_idx];
    end
  end

endmodule

// File: rtl/insight_gpr_snapshot_tx.sv
// Streams a header plus a frozen copy of x1..xN per trigger.
// Ports: clock, reset(n), trig_*, gpr_in, out_* stream, busy, drop_count.
module insight_gpr_snapshot_tx
  import insight_snap_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int XLEN  = DEF_XLEN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trig_valid,
  input  logic                  trig_exception,
  input  logic                  trig_interrupt,
  input  logic [NREGS*XLEN-1:0] gpr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           drop_count
);

  localparam int IW = $clog2(NREGS);

  snap_state_e   state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] rd_idx;
  logic [7:0]    seq;
  logic [XLEN-1:0] rd_data;

  logic hs;
  logic at_last;
  logic fin;
  logic accept;
  logic drop;

  assign hs      = out_valid & out_ready;
  assign at_last = (state == ST_BODY) &&
                   (idx == IW'(NREGS - 1));
  assign fin     = hs & at_last;
  // A trigger on the final handshake chains the next frame.
  assign accept  = trig_valid &
                   ((state == ST_IDLE) | fin);
  assign drop    = trig_valid & ~accept;
  assign idx_nxt = idx + 1'b1;
  assign rd_idx  = (state == ST_HDR) ? '0 : idx_nxt;
  assign busy    = (state != ST_IDLE);

  insight_snap_shadow #(
    .NREGS (NREGS),
    .XLEN  (XLEN)
  ) u_shadow (
    .clock   (clock),
    .cap_en  (accept),
    .gpr_in  (gpr_in),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      idx        <= '0;
      seq        <= '0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        state     <= ST_HDR;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        idx       <= '0;
        seq       <= seq + 8'd1;
        out_data  <= XLEN'(make_hdr(seq, 8'(NREGS),
                       trig_interrupt, trig_exception));
      end else if (hs) begin
        case (state)
          ST_HDR: begin
            state    <= ST_BODY;
            idx      <= '0;
            out_data <= rd_data;
            out_last <= (NREGS == 1);
          end
          ST_BODY: begin
            if (at_last) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              idx      <= idx_nxt;
              out_data <= rd_data;
              out_last <= (idx_nxt == IW'(NREGS - 1));
            end
          end
          default: ;
        endcase
      end
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule
